// File: rtl/ifetch_ctrl_pkg.sv
// Shared definitions for the RISC-V lab core fetch path.
// Holds the legal base opcodes, the fetch FSM state type and the halt cause codes.
package rv_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [1:0] {
        FS_REQ  = 2'b00,
        FS_WAIT = 2'b01,
        FS_HOLD = 2'b10,
        FS_HALT = 2'b11
    } fetch_state_e;

    typedef enum logic [1:0] {
        HC_NONE     = 2'b00,
        HC_ILLEGAL  = 2'b01,
        HC_MISALIGN = 2'b10
    } halt_cause_e;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Bundle of the fetch controller's bus signals.
//   imem_req_*      : request channel to instruction memory (addr = pc)
//   imem_rsp_*      : response channel from instruction memory
//   instr*          : held instruction offered to execute (valid/ready)
//   redirect_*      : next-PC override from execute, used on instr handshake
//   pc/halted/halt_cause : status
// master = fetch controller, slave = memory/execute side.
interface ifetch_ctrl_if #(
    parameter int unsigned PC_W = 11,
    parameter int unsigned ILEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [PC_W-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr;
    logic [PC_W-1:0] instr_pc;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic [1:0]      halt_cause;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
               pc, halted, halt_cause,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
               pc, halted, halt_cause,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifetch_ctrl_opcode_legal.sv
// Combinational opcode check: flags the base RV32I opcodes the lab core executes.
//   opcode_i : instruction bits [6:0]
//   legal_o  : 1 when opcode_i is one of R/I/S/L/B/JAL/JALR
module rv_opcode_legal
    import rv_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       legal_o
);
    always_comb begin
        legal_o = 1'b0;
        case (opcode_i)
            OP_R, OP_I, OP_S, OP_L, OP_B, OP_JAL, OP_JALR: legal_o = 1'b1;
            default:                                       legal_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one memory request at a
// time, holds the fetched word for execute and applies redirects. Halts
// stickily on an illegal opcode or a misaligned redirect target.
//   clk, rst : core clock, asynchronous active-high reset
//   bus      : ifetch_ctrl_if master (memory request/response, instruction
//              handshake, redirect input, pc/halt status)
module ifetch_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned     PC_W     = 11,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     ILEN     = 32
) (
    input logic           clk,
    input logic           rst,
    ifetch_ctrl_if.master bus
);
    fetch_state_e    state_q, state_d;
    halt_cause_e     cause_q, cause_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ipc_q, ipc_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic            legal;

    rv_opcode_legal u_legal (
        .opcode_i (bus.imem_rsp_data[6:0]),
        .legal_o  (legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FS_REQ;
            cause_q <= HC_NONE;
            pc_q    <= RESET_PC;
            ipc_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        case (state_q)
            FS_REQ: begin
                if (bus.imem_req_ready) state_d = FS_WAIT;
            end
            FS_WAIT: begin
                // The word is captured even when illegal so it stays visible after halting.
                if (bus.imem_rsp_valid) begin
                    instr_d = bus.imem_rsp_data;
                    ipc_d   = pc_q;
                    if (legal) begin
                        state_d = FS_HOLD;
                    end else begin
                        state_d = FS_HALT;
                        cause_d = HC_ILLEGAL;
                    end
                end
            end
            FS_HOLD: begin
                if (bus.instr_ready) begin
                    if (!bus.redirect_valid) begin
                        pc_d    = pc_q + PC_W'(4);
                        state_d = FS_REQ;
                    end else if (bus.redirect_pc[1:0] == 2'b00) begin
                        pc_d    = bus.redirect_pc;
                        state_d = FS_REQ;
                    end else begin
                        state_d = FS_HALT;
                        cause_d = HC_MISALIGN;
                    end
                end
            end
            default: ;
        endcase
    end

    // Handshake outputs decode from state only, so no input reaches an output combinationally.
    assign bus.imem_req_valid = (state_q == FS_REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = (state_q == FS_HOLD);
    assign bus.instr          = instr_q;
    assign bus.instr_pc       = ipc_q;
    assign bus.pc             = pc_q;
    assign bus.halted         = (state_q == FS_HALT);
    assign bus.halt_cause     = cause_q;
endmodule

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifetch_ctrl_if #(.PC_W(11), .ILEN(32)) bus ();

    ifetch_ctrl #(.PC_W(11), .RESET_PC(11'h010), .ILEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        xv;
        logic [10:0] xp;
        logic        qv;
        logic [10:0] qa;
        logic        iv;
        logic [31:0] ins;
        logic [10:0] ipc;
        logic [10:0] pc;
        logic        hl;
        logic [1:0]  hc;
    } vec_t;

    vec_t tbl [24];

    int n_chk  = 0;
    int n_pass = 0;
    int req_cnt = 0;
    int ins_cnt = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.imem_req_valid && bus.imem_req_ready) req_cnt++;
            if (bus.instr_valid && bus.instr_ready) ins_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic expect_out(input string tag, input logic qv, input logic [10:0] qa,
                              input logic iv, input logic [31:0] ins, input logic [10:0] ipc,
                              input logic [10:0] pc, input logic hl, input logic [1:0] hc);
        chk({tag, " req_valid"},  32'(bus.imem_req_valid), 32'(qv));
        chk({tag, " req_addr"},   32'(bus.imem_req_addr),  32'(qa));
        chk({tag, " instr_valid"},32'(bus.instr_valid),    32'(iv));
        chk({tag, " instr"},      bus.instr,               ins);
        chk({tag, " instr_pc"},   32'(bus.instr_pc),       32'(ipc));
        chk({tag, " pc"},         32'(bus.pc),             32'(pc));
        chk({tag, " halted"},     32'(bus.halted),         32'(hl));
        chk({tag, " halt_cause"}, 32'(bus.halt_cause),     32'(hc));
    endtask

    task automatic drv(input logic rr, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic xv, input logic [10:0] xp);
        bus.imem_req_ready = rr;
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = rd;
        bus.instr_ready    = ir;
        bus.redirect_valid = xv;
        bus.redirect_pc    = xp;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 11'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0, i0;

        // rr rv rd ir xv xp | qv qa iv ins ipc pc hl hc
        tbl[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 11'h000, 1'b1, 11'h010, 1'b0, 32'h0,        11'h000, 11'h010, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 32'h00500093, 1'b1, 1'b0, 11'h000, 1'b0, 11'h010, 1'b0, 32'h0,        11'h000, 11'h010, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 11'h000, 1'b0, 11'h010, 1'b1, 32'h00500093, 11'h010, 11'h010, 1'b0, 2'd0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 11'h000, 1'b1, 11'h014, 1'b0, 32'h00500093, 11'h010, 11'h014, 1'b0, 2'd0};
        tbl[4]  = '{1'b0, 1'b1, 32'h00A00113, 1'b0, 1'b0, 11'h000, 1'b0, 11'h014, 1'b0, 32'h00500093, 11'h010, 11'h014, 1'b0, 2'd0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 11'h020, 1'b0, 11'h014, 1'b1, 32'h00A00113, 11'h014, 11'h014, 1'b0, 2'd0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 11'h000, 1'b1, 11'h020, 1'b0, 32'h00A00113, 11'h014, 11'h020, 1'b0, 2'd0};
        tbl[7]  = '{1'b0, 1'b1, 32'h00000063, 1'b0, 1'b0, 11'h000, 1'b0, 11'h020, 1'b0, 32'h00A00113, 11'h014, 11'h020, 1'b0, 2'd0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 11'h100, 1'b0, 11'h020, 1'b1, 32'h00000063, 11'h020, 11'h020, 1'b0, 2'd0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 11'h000, 1'b1, 11'h100, 1'b0, 32'h00000063, 11'h020, 11'h100, 1'b0, 2'd0};
        tbl[10] = '{1'b0, 1'b1, 32'h0000006F, 1'b0, 1'b0, 11'h000, 1'b0, 11'h100, 1'b0, 32'h00000063, 11'h020, 11'h100, 1'b0, 2'd0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 11'h7FC, 1'b0, 11'h100, 1'b1, 32'h0000006F, 11'h100, 11'h100, 1'b0, 2'd0};
        tbl[12] = '{1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 11'h300, 1'b1, 11'h7FC, 1'b0, 32'h0000006F, 11'h100, 11'h7FC, 1'b0, 2'd0};
        tbl[13] = '{1'b0, 1'b1, 32'h00000013, 1'b0, 1'b0, 11'h000, 1'b0, 11'h7FC, 1'b0, 32'h0000006F, 11'h100, 11'h7FC, 1'b0, 2'd0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 11'h000, 1'b0, 11'h7FC, 1'b1, 32'h00000013, 11'h7FC, 11'h7FC, 1'b0, 2'd0};
        tbl[15] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 11'h000, 1'b1, 11'h000, 1'b0, 32'h00000013, 11'h7FC, 11'h000, 1'b0, 2'd0};
        tbl[16] = '{1'b0, 1'b1, 32'h00000033, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 32'h00000013, 11'h7FC, 11'h000, 1'b0, 2'd0};
        tbl[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 11'h020, 1'b0, 11'h000, 1'b1, 32'h00000033, 11'h000, 11'h000, 1'b0, 2'd0};
        tbl[18] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 11'h000, 1'b1, 11'h020, 1'b0, 32'h00000033, 11'h000, 11'h020, 1'b0, 2'd0};
        tbl[19] = '{1'b0, 1'b1, 32'h00002003, 1'b0, 1'b0, 11'h000, 1'b0, 11'h020, 1'b0, 32'h00000033, 11'h000, 11'h020, 1'b0, 2'd0};
        tbl[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 11'h102, 1'b0, 11'h020, 1'b1, 32'h00002003, 11'h020, 11'h020, 1'b0, 2'd0};
        tbl[21] = '{1'b1, 1'b1, 32'h00000013, 1'b1, 1'b1, 11'h100, 1'b0, 11'h020, 1'b0, 32'h00002003, 11'h020, 11'h020, 1'b1, 2'd2};
        tbl[22] = '{1'b1, 1'b1, 32'h00000013, 1'b1, 1'b1, 11'h100, 1'b0, 11'h020, 1'b0, 32'h00002003, 11'h020, 11'h020, 1'b1, 2'd2};
        tbl[23] = '{1'b1, 1'b1, 32'h00000013, 1'b1, 1'b1, 11'h100, 1'b0, 11'h020, 1'b0, 32'h00002003, 11'h020, 11'h020, 1'b1, 2'd2};

        // Vector run: sequential fetch, redirects, pc wrap, misaligned redirect halt.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drv(tbl[i].rr, tbl[i].rv, tbl[i].rd, tbl[i].ir, tbl[i].xv, tbl[i].xp);
            expect_out($sformatf("vec%0d", i), tbl[i].qv, tbl[i].qa, tbl[i].iv, tbl[i].ins,
                       tbl[i].ipc, tbl[i].pc, tbl[i].hl, tbl[i].hc);
            step();
        end

        // Request back-pressure plus 5-cycle memory latency.
        do_reset();
        r0 = req_cnt;
        i0 = ins_cnt;
        for (int k = 0; k < 4; k++) begin
            drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 11'h0);
            expect_out($sformatf("stall_req%0d", k), 1'b1, 11'h010, 1'b0, 32'h0, 11'h000, 11'h010, 1'b0, 2'd0);
            step();
        end
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 11'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 11'h0);
            expect_out($sformatf("lat_wait%0d", k), 1'b0, 11'h010, 1'b0, 32'h0, 11'h000, 11'h010, 1'b0, 2'd0);
            step();
        end
        drv(1'b1, 1'b1, 32'h00500093, 1'b1, 1'b0, 11'h0);
        step();
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 11'h0);
        expect_out("lat_hold", 1'b0, 11'h010, 1'b1, 32'h00500093, 11'h010, 11'h010, 1'b0, 2'd0);
        step();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 11'h0);
        expect_out("lat_next", 1'b1, 11'h014, 1'b0, 32'h00500093, 11'h010, 11'h014, 1'b0, 2'd0);
        chk("lat_req_count", 32'(req_cnt - r0), 32'd1);
        chk("lat_instr_count", 32'(ins_cnt - i0), 32'd1);

        // Execute stalls in HOLD; a stray response must not disturb the held word.
        do_reset();
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 11'h0);
        step();
        drv(1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0, 11'h0);
        step();
        for (int k = 0; k < 6; k++) begin
            drv(1'b1, (k == 3), 32'hDEADBEEF, 1'b0, 1'b0, 11'h0);
            expect_out($sformatf("hold%0d", k), 1'b0, 11'h010, 1'b1, 32'h00500093, 11'h010, 11'h010, 1'b0, 2'd0);
            step();
        end
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 11'h0);
        step();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 11'h0);
        expect_out("hold_release", 1'b1, 11'h014, 1'b0, 32'h00500093, 11'h010, 11'h014, 1'b0, 2'd0);

        // Illegal opcode halts with nothing offered to execute.
        do_reset();
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 11'h0);
        step();
        drv(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 11'h0);
        step();
        r0 = req_cnt;
        i0 = ins_cnt;
        for (int k = 0; k < 20; k++) begin
            drv(1'b1, 1'b1, 32'h00000013, 1'b1, 1'b1, 11'h100);
            expect_out($sformatf("illegal%0d", k), 1'b0, 11'h010, 1'b0, 32'hFFFFFFFF, 11'h010, 11'h010, 1'b1, 2'd1);
            step();
        end
        chk("illegal_req_count", 32'(req_cnt - r0), 32'd0);
        chk("illegal_instr_count", 32'(ins_cnt - i0), 32'd0);

        // Reset asserted while waiting for a response; the late response is ignored.
        do_reset();
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 11'h0);
        step();
        drv(1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0, 11'h0);
        step();
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 11'h0);
        step();
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 11'h0);
        step();
        expect_out("rst_pre", 1'b0, 11'h014, 1'b0, 32'h00500093, 11'h010, 11'h014, 1'b0, 2'd0);
        #2 rst = 1'b1;
        #1;
        expect_out("rst_async", 1'b1, 11'h010, 1'b0, 32'h0, 11'h000, 11'h010, 1'b0, 2'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drv(1'b0, 1'b1, 32'h00A00113, 1'b1, 1'b0, 11'h0);
        expect_out("rst_late0", 1'b1, 11'h010, 1'b0, 32'h0, 11'h000, 11'h010, 1'b0, 2'd0);
        step();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 11'h0);
        expect_out("rst_late1", 1'b1, 11'h010, 1'b0, 32'h0, 11'h000, 11'h010, 1'b0, 2'd0);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 11'h0);
        step();
        drv(1'b0, 1'b1, 32'h00A00113, 1'b0, 1'b0, 11'h0);
        step();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 11'h0);
        expect_out("rst_refetch", 1'b0, 11'h010, 1'b1, 32'h00A00113, 11'h010, 11'h010, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
